pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard/stall controller for the 5-stage core. Drives the enable and clear inputs of the
//  IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, which use synchronous clear with
//  clear overriding enable. Resolves, in priority order: memory wait, multicycle EX op,
//  taken branch, load-use hazard.
// PARAMETERS
//  LAT_W   4   width of multicycle latency field; max op latency 2**LAT_W-1
//  REG_W   5   register index width
// PORTS
//  clk          in   1      core clock
//  rstn         in   1      synchronous active-low reset
//  id_rs1       in   REG_W  source reg 1 of instruction in ID
//  id_rs2       in   REG_W  source reg 2 of instruction in ID
//  id_use_rs1   in   1      ID instruction reads rs1
//  id_use_rs2   in   1      ID instruction reads rs2
//  ex_rd        in   REG_W  dest reg of instruction in EX
//  ex_is_load   in   1      EX instruction is a load
//  ex_mc_start  in   1      EX instruction is a multicycle op (FPU/div)
//  ex_mc_lat    in   LAT_W  stall cycles that op needs (0 = none)
//  br_taken     in   1      branch/jump resolved taken in EX
//  mem_stall    in   1      data memory not ready; freeze whole pipe
//  if_en,id_en,ex_en,mem_en,wb_en  out 1 each  pipeline register enables
//  id_clr,ex_clr,mem_clr           out 1 each  clear IF/ID, ID/EX, EX/MEM
//  mc_busy      out  1      FSM not IDLE
//  perf_stall   out  32     stall-cycle count (see CONFIGURATION)
//  perf_flush   out  32     taken-branch flush count
// BEHAVIOUR
//  Clock clk, reset rstn: synchronous, active-low. While rstn=0: FSM=IDLE, cnt=0,
//  all *_en=1, all *_clr=0, mc_busy=0, perf counters=0.
//  Defaults: all *_en=1, all *_clr=0. Outputs combinational from inputs+state, 0 latency.
//  P1 mem_stall=1: all *_en=0, all *_clr=0 (no clear into a frozen register).
//  P2 mc stall = (IDLE & ex_mc_start & ex_mc_lat!=0) | BUSY:
//     if_en=id_en=ex_en=0, mem_clr=1; br_taken and load-use ignored.
//  P3 br_taken: id_clr=1, ex_clr=1, enables stay 1.
//  P4 load-use = ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) |
//     (id_use_rs2 & id_rs2==ex_rd)): if_en=id_en=0, ex_clr=1.
//  FSM (mc_stall_fsm): IDLE, BUSY, DONE.
//   IDLE: start & lat>=2 -> BUSY, cnt<=lat-1; start & lat==1 -> DONE; lat==0 -> stay.
//   BUSY: cnt decrements each cycle; cnt==1 -> DONE. Counts during mem_stall.
//   DONE: ex_mc_start ignored (same op still in ID/EX); no mc stall;
//         -> IDLE when mem_stall=0 (op has advanced), else hold DONE.
//   Net: an op of latency N stalls exactly N cycles (start cycle + N-1 BUSY cycles).
//   ex_mc_start in BUSY/DONE ignored. Reset mid-BUSY -> IDLE, cnt=0 next edge.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: perf_stall +1 each cycle any of if_en/id_en=0 with rstn=1;
//   perf_flush +1 each cycle P3 wins; both wrap at 2**32.
//  Undefined: no counter flops; perf_stall=perf_flush=0 constantly.
// STRUCTURE
//  pipe_ctrl_pkg: mc_state_t enum {IDLE,BUSY,DONE}, REG_ZERO constant.
//  Sub-module mc_stall_fsm: FSM + cnt, outputs mc_stall, mc_busy.
//  Top: priority mux, hazard compare, optional perf counters.
// TESTING
//  1 ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> if_en=id_en=0, ex_clr=1 one cycle;
//    same with ex_rd=0 -> no stall.
//  2 br_taken=1 with load-use active -> id_clr=ex_clr=1, all en=1 (branch wins).
//  3 ex_mc_start=1, lat=4, held 5 cycles -> ex_en=0 & mem_clr=1 exactly 4 cycles, then
//    ex_en=1 in DONE; lat=1 -> 1 stall cycle; lat=0 -> none.
//  4 lat=3, mem_stall=1 in 2nd-4th cycles -> all en=0, all clr=0 while high; FSM stays
//    DONE until mem_stall=0, then IDLE; no retrigger.
//  5 rstn=0 during BUSY (cnt=2) -> next cycle IDLE, mc_busy=0, all en=1.
//  6 HAZ_PERF_CNT_EN: test 3 (lat=4) then one br_taken -> perf_stall=4, perf_flush=1;
//    undefined -> both 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: multicycle FSM states and the
// hard-wired zero register index.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from the core and register enable/clear outputs to the pipeline.
// The core side is the master; the hazard controller is the slave.
interface pipe_hazard_ctrl_if #(
  parameter int LAT_W = 4,
  parameter int REG_W = 5
);
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] ex_rd;
  logic             ex_is_load;
  logic             ex_mc_start;
  logic [LAT_W-1:0] ex_mc_lat;
  logic             br_taken;
  logic             mem_stall;

  logic             if_en;
  logic             id_en;
  logic             ex_en;
  logic             mem_en;
  logic             wb_en;
  logic             id_clr;
  logic             ex_clr;
  logic             mem_clr;
  logic             mc_busy;
  logic [31:0]      perf_stall;
  logic [31:0]      perf_flush;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_mc_start, ex_mc_lat, br_taken, mem_stall,
    input  if_en, id_en, ex_en, mem_en, wb_en, id_clr, ex_clr, mem_clr,
           mc_busy, perf_stall, perf_flush
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_mc_start, ex_mc_lat, br_taken, mem_stall,
    output if_en, id_en, ex_en, mem_en, wb_en, id_clr, ex_clr, mem_clr,
           mc_busy, perf_stall, perf_flush
  );
endinterface

// File: rtl/pipe_hazard_ctrl_mc_stall_fsm.sv
// Multicycle EX-op stall tracker: an op of latency N stalls for the start cycle plus
// N-1 BUSY cycles, then sits in DONE until the op leaves ID/EX.
module mc_stall_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ex_mc_start,
  input  logic [LAT_W-1:0] ex_mc_lat,
  input  logic             mem_stall,
  output logic             mc_stall,
  output logic             mc_busy
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]       state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;

  assign mc_stall = ((state_q == ST_IDLE) && ex_mc_start && (ex_mc_lat != '0))
                  || (state_q == ST_BUSY);
  assign mc_busy  = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ex_mc_start) begin
          if (ex_mc_lat >= LAT_W'(2)) begin
            state_d = ST_BUSY;
            cnt_d   = ex_mc_lat - LAT_W'(1);
          end else if (ex_mc_lat == LAT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      // Counting continues under mem_stall: the functional unit keeps working.
      ST_BUSY: begin
        if (cnt_q == LAT_W'(1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      // The finished op is still in ID/EX until an unfrozen edge moves it on.
      ST_DONE: begin
        if (!mem_stall) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage core: priority mux over memory wait,
// multicycle op, taken branch and load-use. Define HAZ_PERF_CNT_EN for perf counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LAT_W = 4,
  parameter int REG_W = 5
) (
  input logic               clk,
  input logic               rstn,
  pipe_hazard_ctrl_if.slave bus
);

  logic mc_stall;
  logic mc_busy_raw;
  logic load_use;
  logic rs1_hit, rs2_hit;

  mc_stall_fsm #(.LAT_W(LAT_W)) u_mc_fsm (
    .clk        (clk),
    .rstn       (rstn),
    .ex_mc_start(bus.ex_mc_start),
    .ex_mc_lat  (bus.ex_mc_lat),
    .mem_stall  (bus.mem_stall),
    .mc_stall   (mc_stall),
    .mc_busy    (mc_busy_raw)
  );

  assign rs1_hit  = bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd);
  assign rs2_hit  = bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd);
  assign load_use = bus.ex_is_load && (bus.ex_rd != REG_W'(REG_ZERO)) && (rs1_hit || rs2_hit);

  assign bus.mc_busy = rstn && mc_busy_raw;

  // Outputs are forced to the free-running defaults while reset is held.
  always_comb begin
    bus.if_en   = 1'b1;
    bus.id_en   = 1'b1;
    bus.ex_en   = 1'b1;
    bus.mem_en  = 1'b1;
    bus.wb_en   = 1'b1;
    bus.id_clr  = 1'b0;
    bus.ex_clr  = 1'b0;
    bus.mem_clr = 1'b0;
    if (!rstn) begin
      bus.if_en = 1'b1;
    end else if (bus.mem_stall) begin
      bus.if_en  = 1'b0;
      bus.id_en  = 1'b0;
      bus.ex_en  = 1'b0;
      bus.mem_en = 1'b0;
      bus.wb_en  = 1'b0;
    end else if (mc_stall) begin
      bus.if_en   = 1'b0;
      bus.id_en   = 1'b0;
      bus.ex_en   = 1'b0;
      bus.mem_clr = 1'b1;
    end else if (bus.br_taken) begin
      bus.id_clr = 1'b1;
      bus.ex_clr = 1'b1;
    end else if (load_use) begin
      bus.if_en  = 1'b0;
      bus.id_en  = 1'b0;
      bus.ex_clr = 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic        flush_win;

  assign flush_win    = rstn && !bus.mem_stall && !mc_stall && bus.br_taken;
  assign perf_stall_d = (!bus.if_en || !bus.id_en) ? perf_stall_q + 32'd1 : perf_stall_q;
  assign perf_flush_d = flush_win ? perf_flush_q + 32'd1 : perf_flush_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign bus.perf_stall = perf_stall_q;
  assign bus.perf_flush = perf_flush_q;
`else
  assign bus.perf_stall = '0;
  assign bus.perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expectations follow HAZ_PERF_CNT_EN as compiled.
module tb_pipe_hazard_ctrl;

  localparam int LAT_W = 4;
  localparam int REG_W = 5;

  // {if_en,id_en,ex_en,mem_en,wb_en,id_clr,ex_clr,mem_clr}
  localparam logic [7:0] C_FREE = 8'b11111_000;
  localparam logic [7:0] C_LU   = 8'b00111_010;
  localparam logic [7:0] C_BR   = 8'b11111_110;
  localparam logic [7:0] C_MC   = 8'b00011_001;
  localparam logic [7:0] C_FRZ  = 8'b00000_000;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  pipe_hazard_ctrl_if #(.LAT_W(LAT_W), .REG_W(REG_W)) hif ();

  pipe_hazard_ctrl #(.LAT_W(LAT_W), .REG_W(REG_W)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ctl();
    return {hif.if_en, hif.id_en, hif.ex_en, hif.mem_en, hif.wb_en,
            hif.id_clr, hif.ex_clr, hif.mem_clr};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hif.id_rs1      = '0;
    hif.id_rs2      = '0;
    hif.id_use_rs1  = 1'b0;
    hif.id_use_rs2  = 1'b0;
    hif.ex_rd       = '0;
    hif.ex_is_load  = 1'b0;
    hif.ex_mc_start = 1'b0;
    hif.ex_mc_lat   = '0;
    hif.br_taken    = 1'b0;
    hif.mem_stall   = 1'b0;
  endtask

  task automatic set_load_use(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs1);
    hif.ex_is_load = 1'b1;
    hif.ex_rd      = rd;
    hif.id_rs1     = rs1;
    hif.id_use_rs1 = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 1'b0;
    set_load_use(5'd5, 5'd5);
    hif.br_taken = 1'b1;
    step();
    step();
    #1;
    checks++;
    if (ctl() !== C_FREE) begin
      errors++;
      $display("FAIL reset_ctl got=%b exp=%b", ctl(), C_FREE);
    end
    checks++;
    if (hif.mc_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b exp=0", hif.mc_busy);
    end
    checks++;
    if (hif.perf_stall !== 32'd0 || hif.perf_flush !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf got=%0d/%0d exp=0/0", hif.perf_stall, hif.perf_flush);
    end
    clear_inputs();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_load_use();
    logic [7:0] exp_v [5];
    exp_v = '{C_LU, C_LU, C_FREE, C_FREE, C_FREE};
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      case (i)
        0: set_load_use(5'd5, 5'd5);
        1: begin
          hif.ex_is_load = 1'b1; hif.ex_rd = 5'd9;
          hif.id_rs2 = 5'd9; hif.id_use_rs2 = 1'b1;
        end
        2: set_load_use(5'd0, 5'd0);
        3: begin set_load_use(5'd5, 5'd5); hif.id_use_rs1 = 1'b0; end
        default: begin set_load_use(5'd5, 5'd5); hif.ex_is_load = 1'b0; end
      endcase
      #1;
      checks++;
      if (ctl() !== exp_v[i]) begin
        errors++;
        $display("FAIL load_use[%0d] got=%b exp=%b", i, ctl(), exp_v[i]);
      end
      step();
    end
    clear_inputs();
    #1;
    checks++;
    if (ctl() !== C_FREE) begin
      errors++;
      $display("FAIL load_use_release got=%b exp=%b", ctl(), C_FREE);
    end
    step();
  endtask

  task automatic test_branch();
    clear_inputs();
    set_load_use(5'd5, 5'd5);
    hif.br_taken = 1'b1;
    #1;
    checks++;
    if (ctl() !== C_BR) begin
      errors++;
      $display("FAIL branch_over_lu got=%b exp=%b", ctl(), C_BR);
    end
    step();
    clear_inputs();
    step();
  endtask

  // lat drives the multicycle op; br_taken is raised during stall cycle 2 and must be ignored.
  task automatic run_mc(input logic [LAT_W-1:0] lat, input int hold, input int nstall,
                        input string tag);
    logic [7:0] e;
    logic       eb;
    for (int i = 0; i < hold; i++) begin
      clear_inputs();
      hif.ex_mc_start = 1'b1;
      hif.ex_mc_lat   = lat;
      if (i == 2) begin
        hif.br_taken = 1'b1;
        set_load_use(5'd3, 5'd3);
      end
      #1;
      e  = (i < nstall) ? C_MC : ((i == 2) ? C_BR : C_FREE);
      eb = (i >= 1) && (nstall > 0);
      checks++;
      if (ctl() !== e) begin
        errors++;
        $display("FAIL %s_ctl[%0d] got=%b exp=%b", tag, i, ctl(), e);
      end
      checks++;
      if (hif.mc_busy !== eb) begin
        errors++;
        $display("FAIL %s_busy[%0d] got=%b exp=%b", tag, i, hif.mc_busy, eb);
      end
      step();
    end
    clear_inputs();
    #1;
    checks++;
    if (hif.mc_busy !== 1'b0 || ctl() !== C_FREE) begin
      errors++;
      $display("FAIL %s_after got busy=%b ctl=%b exp busy=0 ctl=%b", tag, hif.mc_busy, ctl(), C_FREE);
    end
    step();
  endtask

  task automatic test_multicycle();
    run_mc(4'd4, 5, 4, "mc_lat4");
    run_mc(4'd1, 2, 1, "mc_lat1");
    run_mc(4'd0, 2, 0, "mc_lat0");
  endtask

  task automatic test_mc_mem_stall();
    logic [7:0] e_ctl [6];
    logic       e_bsy [6];
    e_ctl = '{C_MC, C_FRZ, C_FRZ, C_FRZ, C_FREE, C_FREE};
    e_bsy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      hif.ex_mc_start = (i < 5);
      hif.ex_mc_lat   = 4'd3;
      hif.mem_stall   = (i >= 1 && i <= 3);
      #1;
      checks++;
      if (ctl() !== e_ctl[i]) begin
        errors++;
        $display("FAIL mc_mem_ctl[%0d] got=%b exp=%b", i, ctl(), e_ctl[i]);
      end
      checks++;
      if (hif.mc_busy !== e_bsy[i]) begin
        errors++;
        $display("FAIL mc_mem_busy[%0d] got=%b exp=%b", i, hif.mc_busy, e_bsy[i]);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_busy();
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      hif.ex_mc_start = 1'b1;
      hif.ex_mc_lat   = 4'd4;
      if (i == 2) begin
        #1;
        checks++;
        if (ctl() !== C_MC || hif.mc_busy !== 1'b1) begin
          errors++;
          $display("FAIL rst_busy_pre got ctl=%b busy=%b exp ctl=%b busy=1", ctl(), hif.mc_busy, C_MC);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (ctl() !== C_FREE || hif.mc_busy !== 1'b0) begin
          errors++;
          $display("FAIL rst_busy_hold got ctl=%b busy=%b exp ctl=%b busy=0", ctl(), hif.mc_busy, C_FREE);
        end
      end
      step();
    end
    rstn = 1'b1;
    clear_inputs();
    #1;
    checks++;
    if (ctl() !== C_FREE || hif.mc_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy_post got ctl=%b busy=%b exp ctl=%b busy=0", ctl(), hif.mc_busy, C_FREE);
    end
    step();
  endtask

  task automatic test_perf();
    logic [31:0] es, ef;
`ifdef HAZ_PERF_CNT_EN
    es = 32'd4;
    ef = 32'd1;
`else
    es = 32'd0;
    ef = 32'd0;
`endif
    clear_inputs();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      hif.ex_mc_start = 1'b1;
      hif.ex_mc_lat   = 4'd4;
      step();
    end
    clear_inputs();
    step();
    hif.br_taken = 1'b1;
    step();
    clear_inputs();
    step();
    checks++;
    if (hif.perf_stall !== es) begin
      errors++;
      $display("FAIL perf_stall got=%0d exp=%0d", hif.perf_stall, es);
    end
    checks++;
    if (hif.perf_flush !== ef) begin
      errors++;
      $display("FAIL perf_flush got=%0d exp=%0d", hif.perf_flush, ef);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    clear_inputs();
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_multicycle();
    test_mc_mem_stall();
    test_reset_mid_busy();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
